// File: rtl/instr_pkg.sv
// Shared instruction definitions: operation select, MIPS opcode/funct
// constants, loader FSM states and word-packing helpers.
// The instruction decoder uses the same opcode/funct constants.
package instr_pkg;

    typedef enum logic [3:0] {
        OP_LW   = 4'd0,
        OP_SW   = 4'd1,
        OP_J    = 4'd2,
        OP_JR   = 4'd3,
        OP_JAL  = 4'd4,
        OP_BNE  = 4'd5,
        OP_BEQ  = 4'd6,
        OP_XORI = 4'd7,
        OP_ADDI = 4'd8,
        OP_ADD  = 4'd9,
        OP_SUB  = 4'd10,
        OP_SLT  = 4'd11
    } op_e;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_XORI  = 6'b001110;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_JAL   = 6'b000011;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_JR  = 6'b001000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_e;

    function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] opc, input logic [25:0] target);
        return {opc, target};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {OPC_RTYPE, rs, rt, rd, 5'b00000, funct};
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: turns an operation select plus register,
// immediate and target fields into a 32-bit MIPS word, flagging illegal ops.
// Optional macro ENC_FIELD_CHECK_EN additionally rejects JR with nonzero
// rt/rd and J/JAL targets whose low two bits are nonzero.
module instr_pack
    import instr_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    // Select the encoding format for the requested operation; unused fields are dropped.
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (op)
            OP_LW:   word = enc_i(OPC_LW,   rs, rt, imm);
            OP_SW:   word = enc_i(OPC_SW,   rs, rt, imm);
            OP_BNE:  word = enc_i(OPC_BNE,  rs, rt, imm);
            OP_BEQ:  word = enc_i(OPC_BEQ,  rs, rt, imm);
            OP_XORI: word = enc_i(OPC_XORI, rs, rt, imm);
            OP_ADDI: word = enc_i(OPC_ADDI, rs, rt, imm);
            OP_J: begin
                word = enc_j(OPC_J, target);
`ifdef ENC_FIELD_CHECK_EN
                illegal = (target[1:0] != 2'b00);
`endif
            end
            OP_JAL: begin
                word = enc_j(OPC_JAL, target);
`ifdef ENC_FIELD_CHECK_EN
                illegal = (target[1:0] != 2'b00);
`endif
            end
            OP_JR: begin
                word = enc_r(rs, 5'd0, 5'd0, FUNCT_JR);
`ifdef ENC_FIELD_CHECK_EN
                illegal = (rt != 5'd0) || (rd != 5'd0);
`endif
            end
            OP_ADD:  word = enc_r(rs, rt, rd, FUNCT_ADD);
            OP_SUB:  word = enc_r(rs, rt, rd, FUNCT_SUB);
            OP_SLT:  word = enc_r(rs, rt, rd, FUNCT_SLT);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: accepts symbolic instructions on a valid/ready
// stream, packs them into MIPS words and writes them sequentially into
// instruction memory through a 2-entry buffered write port.
// Optional macro ENC_FIELD_CHECK_EN enables extra JR/J/JAL field checks.
module instr_encoder_loader
    import instr_pkg::*;
#(
    parameter int                ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W-2:0] count,
    output logic              done,
    output logic              err,
    output logic              wrap
);

    state_e       state;
    logic [31:0]  pack_word;
    logic         pack_illegal;

    logic [31:0]  fifo_data [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   fifo_cnt;
    logic         fifo_full;
    logic         fifo_empty;

    logic         accept;
    logic         push;
    logic         pop;
    logic         discard;
    logic [ADDR_W:0] addr_next;

    instr_pack u_pack (
        .op      (in_op),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .imm     (in_imm),
        .target  (in_target),
        .word    (pack_word),
        .illegal (pack_illegal)
    );

    assign fifo_full  = (fifo_cnt == 2'd2);
    assign fifo_empty = (fifo_cnt == 2'd0);
    assign in_ready   = (state == ST_LOAD) && !fifo_full;
    assign accept     = in_valid && in_ready;
    assign push       = accept && !pack_illegal;
    assign mem_we     = !fifo_empty;
    assign pop        = mem_we && mem_ready;
    assign mem_wdata  = fifo_data[rd_ptr];
    // A restart from ERROR abandons the old program, so leftover words are dropped.
    assign discard    = (state == ST_ERROR) && start;
    // Extra top bit is the carry out that marks an address wrap-around.
    assign addr_next  = {1'b0, mem_addr} + (ADDR_W+1)'(4);

    // Two-entry write buffer; the head entry drives the memory write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            fifo_cnt     <= 2'd0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
        end else if (discard) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= pack_word;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Session FSM with registered status outputs and the write-address/count tracker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            mem_addr <= BASE_ADDR;
            count    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (pop) begin
                mem_addr <= addr_next[ADDR_W-1:0];
                count    <= count + (ADDR_W-1)'(1);
                if (addr_next[ADDR_W]) begin
                    wrap <= 1'b1;
                end
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_LOAD;
                        mem_addr <= BASE_ADDR;
                        count    <= '0;
                        err      <= 1'b0;
                        wrap     <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (pack_illegal) begin
                            err   <= 1'b1;
                            state <= ST_ERROR;
                        end else if (in_last) begin
                            state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (fifo_empty) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                ST_ERROR: begin
                    if (start) begin
                        state    <= ST_LOAD;
                        mem_addr <= BASE_ADDR;
                        count    <= '0;
                        err      <= 1'b0;
                        wrap     <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: directed instructions push their
// expected {address, word} into a queue; monitors pop and compare on every
// completed memory write. A second instance (ADDR_W=4, BASE_ADDR=8) covers
// address wrap-around. Default build (ENC_FIELD_CHECK_EN undefined).
module tb_instr_encoder_loader;
    import instr_pkg::*;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start_w = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_op = '0;
    logic [4:0]  in_rs = '0;
    logic [4:0]  in_rt = '0;
    logic [4:0]  in_rd = '0;
    logic [15:0] in_imm = '0;
    logic [25:0] in_target = '0;
    logic        in_last = 1'b0;
    logic        mem_ready = 1'b0;

    logic        in_ready, mem_we, done, err, wrap;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [10:0] count;

    logic        in_ready_w, mem_we_w, done_w, err_w, wrap_w;
    logic [3:0]  mem_addr_w;
    logic [31:0] mem_wdata_w;
    logic [2:0]  count_w;

    int          checks = 0;
    int          errors = 0;
    int          done_seen = 0;
    int          done_exp = 0;
    bit          sel = 1'b0;
    logic [11:0] next_addr = '0;
    logic [3:0]  next_addr_w = '0;
    wr_t         exp_q[$];
    wr_t         exp_w_q[$];

    instr_encoder_loader #(.ADDR_W(12), .BASE_ADDR(12'd0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last), .mem_we(mem_we), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count), .done(done),
        .err(err), .wrap(wrap)
    );

    instr_encoder_loader #(.ADDR_W(4), .BASE_ADDR(4'd8)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start_w), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last), .mem_we(mem_we_w), .mem_ready(mem_ready),
        .mem_addr(mem_addr_w), .mem_wdata(mem_wdata_w), .count(count_w), .done(done_w),
        .err(err_w), .wrap(wrap_w)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: bound expired", name);
    endtask

    // Offer one instruction; push the expected write when the handshake will occur.
    task automatic applyStimulus(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                                 input logic last, input logic [31:0] word, input bit legal);
        bit acc = 1'b0;
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_imm = imm; in_target = tgt; in_last = last; in_valid = 1'b1;
        for (int n = 0; n < 200 && !acc; n++) begin
            if (sel ? in_ready_w : in_ready) begin
                acc = 1'b1;
                if (legal) begin
                    if (sel) begin
                        exp_w_q.push_back('{addr: {8'd0, next_addr_w}, data: word});
                        next_addr_w = next_addr_w + 4'd4;
                    end else begin
                        exp_q.push_back('{addr: next_addr, data: word});
                        next_addr = next_addr + 12'd4;
                    end
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        if (!acc) failNow("accept_timeout");
    endtask

    task automatic startSession(input bit w);
        sel = w;
        if (w) begin start_w = 1'b1; next_addr_w = 4'd8; end
        else   begin start = 1'b1;   next_addr = 12'd0; end
        @(posedge clk); #1;
        start = 1'b0;
        start_w = 1'b0;
    endtask

    task automatic waitDone(input bit w, input int exp_count);
        int n = 0;
        while (!(w ? done_w : done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            failNow("done_timeout");
        end else begin
            done_exp++;
            checkOutput("count_at_done", w ? 32'(count_w) : 32'(count), 32'(exp_count));
            @(negedge clk);
            checkOutput("done_one_cycle", 32'(w ? done_w : done), 32'd0);
        end
        @(posedge clk); #1;
    endtask

    // Main-instance write monitor: compares the head of the write port against the scoreboard.
    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                failNow("unexpected_write");
            end else begin
                checkOutput(mem_ready ? "wr_addr" : "hold_addr", 32'(mem_addr), 32'(exp_q[0].addr));
                checkOutput(mem_ready ? "wr_data" : "hold_data", mem_wdata, exp_q[0].data);
                if (mem_ready) void'(exp_q.pop_front());
            end
        end
        if (done) done_seen++;
    end

    // Wrap-instance write monitor.
    always @(negedge clk) begin
        if (mem_we_w) begin
            if (exp_w_q.size() == 0) begin
                failNow("unexpected_write_w");
            end else begin
                checkOutput("wr_addr_w", 32'(mem_addr_w), 32'(exp_w_q[0].addr));
                checkOutput("wr_data_w", mem_wdata_w, exp_w_q[0].data);
                if (mem_ready) void'(exp_w_q.pop_front());
            end
        end
        if (done_w) done_seen++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_addr_w", 32'(mem_addr_w), 32'd8);
        checkOutput("rst_outputs", {27'd0, in_ready, done, err, wrap, |count}, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ADDI single instruction
        mem_ready = 1'b1;
        startSession(0);
        applyStimulus(OP_ADDI, 5'd0, 5'd8, 5'd17, 16'd5, 26'h155, 1'b1, 32'h20080005, 1'b1);
        waitDone(0, 1);
        checkOutput("wrap_clear", 32'(wrap), 32'd0);

        // ADD then LW
        startSession(0);
        applyStimulus(OP_ADD, 5'd9, 5'd10, 5'd8, 16'hBEEF, 26'h0, 1'b0, 32'h012A4020, 1'b1);
        applyStimulus(OP_LW, 5'd29, 5'd8, 5'd3, 16'd4, 26'h0, 1'b1, 32'h8FA80004, 1'b1);
        waitDone(0, 2);

        // J then JR
        startSession(0);
        applyStimulus(OP_J, 5'd4, 5'd4, 5'd4, 16'h1234, 26'h10, 1'b0, 32'h08000010, 1'b1);
        applyStimulus(OP_JR, 5'd31, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b1, 32'h03E00008, 1'b1);
        waitDone(0, 2);

        // SLT then JAL back to back
        startSession(0);
        applyStimulus(OP_SLT, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 32'h0022182A, 1'b1);
        applyStimulus(OP_JAL, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FFFFFC, 1'b1, 32'h0FFFFFFC, 1'b1);
        waitDone(0, 2);

        // Backpressure: three offered while memory stalls for 5 cycles
        mem_ready = 1'b0;
        startSession(0);
        fork
            begin
                applyStimulus(OP_SUB, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 32'h00221822, 1'b1);
                applyStimulus(OP_SW, 5'd4, 5'd5, 5'd0, 16'hFFFC, 26'h0, 1'b0, 32'hAC85FFFC, 1'b1);
                applyStimulus(OP_BEQ, 5'd6, 5'd7, 5'd0, 16'd3, 26'h0, 1'b1, 32'h10C70003, 1'b1);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
                checkOutput("stall_mem_we", 32'(mem_we), 32'd1);
                checkOutput("stall_count", 32'(count), 32'd0);
                mem_ready = 1'b1;
            end
        join
        waitDone(0, 3);

        // Illegal op after one valid word
        startSession(0);
        applyStimulus(OP_XORI, 5'd1, 5'd2, 5'd9, 16'h00FF, 26'h0, 1'b0, 32'h382200FF, 1'b1);
        applyStimulus(4'd13, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("err_set", 32'(err), 32'd1);
        checkOutput("err_in_ready", 32'(in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("err_count", 32'(count), 32'd1);
        checkOutput("err_sticky", 32'(err), 32'd1);
        startSession(0);
        checkOutput("err_cleared", 32'(err), 32'd0);
        checkOutput("restart_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(OP_BNE, 5'd3, 5'd4, 5'd0, 16'hFFFE, 26'h0, 1'b1, 32'h1464FFFE, 1'b1);
        waitDone(0, 1);

        // Address wrap on the narrow instance
        startSession(1);
        applyStimulus(OP_ADDI, 5'd0, 5'd1, 5'd0, 16'd1, 26'h0, 1'b0, 32'h20010001, 1'b1);
        applyStimulus(OP_ADDI, 5'd0, 5'd2, 5'd0, 16'd2, 26'h0, 1'b0, 32'h20020002, 1'b1);
        applyStimulus(OP_ADDI, 5'd0, 5'd3, 5'd0, 16'd3, 26'h0, 1'b0, 32'h20030003, 1'b1);
        applyStimulus(OP_ADDI, 5'd0, 5'd4, 5'd0, 16'd4, 26'h0, 1'b0, 32'h20040004, 1'b1);
        applyStimulus(OP_ADDI, 5'd0, 5'd5, 5'd0, 16'd5, 26'h0, 1'b1, 32'h20050005, 1'b1);
        waitDone(1, 5);
        checkOutput("wrap_set", 32'(wrap_w), 32'd1);
        checkOutput("wrap_addr_after", 32'(mem_addr_w), 32'd12);

        // Reset asserted during FLUSH with two words buffered
        mem_ready = 1'b0;
        startSession(0);
        applyStimulus(OP_ADD, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b0, 32'h00210820, 1'b1);
        applyStimulus(OP_SUB, 5'd2, 5'd2, 5'd2, 16'h0, 26'h0, 1'b1, 32'h00421022, 1'b1);
        checkOutput("flush_we", 32'(mem_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_flush_we", 32'(mem_we), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("post_rst_we", 32'(mem_we), 32'd0);
        checkOutput("post_rst_addr", 32'(mem_addr), 32'd0);
        checkOutput("post_rst_count", 32'(count), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("done_pulses", 32'(done_seen), 32'(done_exp));
        checkOutput("queue_drained", 32'(exp_q.size() + exp_w_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
